// File: rtl/hazard_stall_unit_pkg.sv
// ---------------------------------------------------------------------------
// hazard_stall_unit_pkg
// Shared types and constants for the pipeline interlock controller.
//   state_t  : interlock FSM state (RUN / STALL)
//   shadow_t : shadow copy of one pipeline stage's destination info
//   BUBBLE   : shadow value of an empty (bubbled) stage
//   REG_ZERO : hard-wired zero register, never a hazard source
// ---------------------------------------------------------------------------
package hazard_stall_unit_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    typedef struct packed {
        logic [4:0] rw;
        logic       regwr;
        logic       memrd;
    } shadow_t;

    localparam shadow_t    BUBBLE   = '0;
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_stall_unit_sat_counter.sv
// ---------------------------------------------------------------------------
// hazard_stall_unit_sat_counter
// Saturating up-counter used for the interlock performance counters.
//   i_clk   : clock, rising edge
//   i_rst   : asynchronous active-high reset (count -> 0)
//   i_inc   : increment by one this cycle (held at all-ones once reached)
//   i_clr   : synchronous clear, takes priority over i_inc
//   o_count : current count
// ---------------------------------------------------------------------------
module hazard_stall_unit_sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/hazard_stall_unit.sv
// ---------------------------------------------------------------------------
// hazard_stall_unit
// Interlock controller for the 5-stage IF/ID/EX/MEM/WR pipeline. Detects the
// hazards forwarding cannot cover (load-use, taken branch resolved in MEM)
// and drives PC / IF-ID write enables plus bubble/flush controls. A shadow
// copy of the E/M/W destination info is kept locally, so only decode-stage
// inputs and the MEM branch result are needed.
//   clk, rst    : clock (rising) / asynchronous active-high reset
//   D_Rs, D_Rt  : ID-stage source registers, qualified by D_UseRs/D_UseRt
//   D_Rw        : ID-stage destination, D_RegWr write flag, D_MemRd is-load
//   M_BrTaken   : MEM-stage branch/jump taken (redirect, highest priority)
//   PCWr/IFIDWr : PC and IF/ID write enables (low while stalling)
//   IFIDFlush, IDEXFlush, EXMEMFlush : zero/bubble the stage on next edge
//   Stall       : load-use stall active this cycle
//   StallCnt    : saturating count of stall cycles since reset
//   FlushCnt    : saturating count of branch flush cycles since reset
// ---------------------------------------------------------------------------
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int unsigned LOAD_STALL = 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       D_Rs,
    input  logic [4:0]       D_Rt,
    input  logic             D_UseRs,
    input  logic             D_UseRt,
    input  logic [4:0]       D_Rw,
    input  logic             D_RegWr,
    input  logic             D_MemRd,
    input  logic             M_BrTaken,
    output logic             PCWr,
    output logic             IFIDWr,
    output logic             IFIDFlush,
    output logic             IDEXFlush,
    output logic             EXMEMFlush,
    output logic             Stall,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    // Remaining stall cycles after the first one, loaded on hazard detect.
    localparam logic [1:0] STALL_RELOAD = 2'(LOAD_STALL - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_cnt;
    logic [1:0] w_cnt_nxt;

    shadow_t    r_e;
    shadow_t    r_m;
    shadow_t    r_w;
    shadow_t    w_d;

    logic       w_hazard;
    logic       w_unused_shadow_w;

    assign w_d = '{rw: D_Rw, regwr: D_RegWr, memrd: D_MemRd};

    // W shadow is kept for the forwarding partner's view of the pipe; no
    // interlock decision depends on it.
    assign w_unused_shadow_w = ^r_w;

    // Load in EX whose result an ID-stage read needs; $0 is never a hazard.
    always_comb begin
        w_hazard = r_e.memrd && r_e.regwr && (r_e.rw != REG_ZERO) &&
                   ((D_UseRs && (r_e.rw == D_Rs)) ||
                    (D_UseRt && (r_e.rw == D_Rt)));
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    // The first stall cycle is spent in RUN; STALL covers the remaining
    // LOAD_STALL-1 cycles, leaving once the counter would reach zero.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (M_BrTaken) begin
            w_state_nxt = RUN;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_hazard && (LOAD_STALL > 1)) begin
                        w_state_nxt = STALL;
                        w_cnt_nxt   = STALL_RELOAD;
                    end
                end
                STALL: begin
                    if (r_cnt <= 2'd1) begin
                        w_state_nxt = RUN;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt - 2'd1;
                    end
                end
                default: begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        PCWr       = 1'b1;
        IFIDWr     = 1'b1;
        IFIDFlush  = 1'b0;
        IDEXFlush  = 1'b0;
        EXMEMFlush = 1'b0;
        Stall      = 1'b0;
        if (M_BrTaken) begin
            IFIDFlush  = 1'b1;
            IDEXFlush  = 1'b1;
            EXMEMFlush = 1'b1;
        end else if ((r_state == STALL) || w_hazard) begin
            PCWr      = 1'b0;
            IFIDWr    = 1'b0;
            IDEXFlush = 1'b1;
            Stall     = 1'b1;
        end
    end

    // ---------------- Shadow pipeline ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_e <= BUBBLE;
            r_m <= BUBBLE;
            r_w <= BUBBLE;
        end else begin
            r_w <= r_m;
            if (M_BrTaken) begin
                r_m <= BUBBLE;
                r_e <= BUBBLE;
            end else begin
                r_m <= r_e;
                r_e <= IDEXFlush ? BUBBLE : w_d;
            end
        end
    end

    // ---------------- Performance counters ----------------
    hazard_stall_unit_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_inc   (Stall),
        .i_clr   (1'b0),
        .o_count (StallCnt)
    );

    hazard_stall_unit_sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_inc   (M_BrTaken),
        .i_clr   (1'b0),
        .o_count (FlushCnt)
    );

endmodule

// File: tb/tb_hazard_stall_unit.sv
module tb_hazard_stall_unit;

    logic       clk;
    logic       rst;
    logic [4:0] rs, rt, rw;
    logic       urs, urt, wr, ld, br;

    logic pcwr [3];
    logic ifidwr [3];
    logic ifidfl [3];
    logic idexfl [3];
    logic exmemfl [3];
    logic stl [3];
    logic [15:0] sc0, sc1, fc0, fc1;
    logic [3:0]  sc2, fc2;

    // Instance 0: LOAD_STALL=1, instance 1: LOAD_STALL=3, instance 2: 4-bit counters.
    hazard_stall_unit #(.LOAD_STALL(1), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .D_Rs(rs), .D_Rt(rt), .D_UseRs(urs), .D_UseRt(urt),
        .D_Rw(rw), .D_RegWr(wr), .D_MemRd(ld), .M_BrTaken(br),
        .PCWr(pcwr[0]), .IFIDWr(ifidwr[0]), .IFIDFlush(ifidfl[0]), .IDEXFlush(idexfl[0]),
        .EXMEMFlush(exmemfl[0]), .Stall(stl[0]), .StallCnt(sc0), .FlushCnt(fc0));

    hazard_stall_unit #(.LOAD_STALL(3), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .D_Rs(rs), .D_Rt(rt), .D_UseRs(urs), .D_UseRt(urt),
        .D_Rw(rw), .D_RegWr(wr), .D_MemRd(ld), .M_BrTaken(br),
        .PCWr(pcwr[1]), .IFIDWr(ifidwr[1]), .IFIDFlush(ifidfl[1]), .IDEXFlush(idexfl[1]),
        .EXMEMFlush(exmemfl[1]), .Stall(stl[1]), .StallCnt(sc1), .FlushCnt(fc1));

    hazard_stall_unit #(.LOAD_STALL(1), .CNT_W(4)) dut2 (
        .clk(clk), .rst(rst), .D_Rs(rs), .D_Rt(rt), .D_UseRs(urs), .D_UseRt(urt),
        .D_Rw(rw), .D_RegWr(wr), .D_MemRd(ld), .M_BrTaken(br),
        .PCWr(pcwr[2]), .IFIDWr(ifidwr[2]), .IFIDFlush(ifidfl[2]), .IDEXFlush(idexfl[2]),
        .EXMEMFlush(exmemfl[2]), .Stall(stl[2]), .StallCnt(sc2), .FlushCnt(fc2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: what instruction sits in EX, how many extra stall
    // cycles are still owed, and the event tallies.
    int         LS   [3] = '{1, 3, 1};
    int         MAXC [3] = '{65535, 65535, 15};
    logic [4:0] m_rw [3];
    bit         m_wr [3];
    bit         m_ld [3];
    int         m_left [3];
    int         m_sc [3];
    int         m_fc [3];

    // Values seen at the last sampling point, for hand-written sequences.
    int s_pcwr [3];
    int s_stall [3];
    int s_sc [3];

    typedef struct {
        logic [4:0] rs, rt;
        logic       urs, urt;
        logic [4:0] rw;
        logic       wr, ld, br;
        logic       x_pcwr, x_stall, x_idex, x_fl;
    } vec_t;

    vec_t tbl [12];
    vec_t none;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int act_sc(input int k);
        if (k == 0) return int'(sc0);
        if (k == 1) return int'(sc1);
        return int'(sc2);
    endfunction

    function automatic int act_fc(input int k);
        if (k == 0) return int'(fc0);
        if (k == 1) return int'(fc1);
        return int'(fc2);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_rw[k] = '0; m_wr[k] = 0; m_ld[k] = 0;
            m_left[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
        end
    endtask

    task automatic set_in(input logic [4:0] a, input logic [4:0] b, input logic ua,
                          input logic ub, input logic [4:0] d, input logic w,
                          input logic l, input logic t);
        rs = a; rt = b; urs = ua; urt = ub; rw = d; wr = w; ld = l; br = t;
    endtask

    // One pipeline cycle: entered just after a rising edge, checks all DUTs
    // at the falling edge, then advances the model across the next edge.
    task automatic step(input bit do_tbl, input vec_t v, input string tag);
        bit haz;
        bit xs [3];
        bit xb;
        if (rst) model_reset();
        @(negedge clk);
        xb = br;
        for (int k = 0; k < 3; k++) begin
            haz = m_ld[k] && m_wr[k] && (m_rw[k] != 0) &&
                  ((urs && m_rw[k] == rs) || (urt && m_rw[k] == rt));
            xs[k] = !xb && (m_left[k] > 0 || haz);
            s_pcwr[k]  = int'(pcwr[k]);
            s_stall[k] = int'(stl[k]);
            s_sc[k]    = act_sc(k);
            chk($sformatf("%s PCWr[%0d]", tag, k),       int'(pcwr[k]),    int'(!xs[k]));
            chk($sformatf("%s IFIDWr[%0d]", tag, k),     int'(ifidwr[k]),  int'(!xs[k]));
            chk($sformatf("%s IFIDFlush[%0d]", tag, k),  int'(ifidfl[k]),  int'(xb));
            chk($sformatf("%s IDEXFlush[%0d]", tag, k),  int'(idexfl[k]),  int'(xb || xs[k]));
            chk($sformatf("%s EXMEMFlush[%0d]", tag, k), int'(exmemfl[k]), int'(xb));
            chk($sformatf("%s Stall[%0d]", tag, k),      int'(stl[k]),     int'(xs[k]));
            chk($sformatf("%s StallCnt[%0d]", tag, k),   act_sc(k),        m_sc[k]);
            chk($sformatf("%s FlushCnt[%0d]", tag, k),   act_fc(k),        m_fc[k]);
        end
        if (do_tbl) begin
            chk({tag, " tbl PCWr"},       int'(pcwr[0]),    int'(v.x_pcwr));
            chk({tag, " tbl IFIDWr"},     int'(ifidwr[0]),  int'(v.x_pcwr));
            chk({tag, " tbl Stall"},      int'(stl[0]),     int'(v.x_stall));
            chk({tag, " tbl IDEXFlush"},  int'(idexfl[0]),  int'(v.x_idex));
            chk({tag, " tbl IFIDFlush"},  int'(ifidfl[0]),  int'(v.x_fl));
            chk({tag, " tbl EXMEMFlush"}, int'(exmemfl[0]), int'(v.x_fl));
        end
        @(posedge clk);
        if (!rst) begin
            for (int k = 0; k < 3; k++) begin
                if (xb) begin
                    m_rw[k] = '0; m_wr[k] = 0; m_ld[k] = 0; m_left[k] = 0;
                end else if (xs[k]) begin
                    m_rw[k] = '0; m_wr[k] = 0; m_ld[k] = 0;
                    m_left[k] = (m_left[k] > 0) ? m_left[k] - 1 : LS[k] - 1;
                end else begin
                    m_rw[k] = rw; m_wr[k] = wr; m_ld[k] = ld; m_left[k] = 0;
                end
                if (xs[k] && m_sc[k] < MAXC[k]) m_sc[k]++;
                if (xb && m_fc[k] < MAXC[k]) m_fc[k]++;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, none, "reset");
        rst = 1'b0;
    endtask

    initial begin
        none = '{default: '0};
        // {rs, rt, urs, urt, rw, wr, ld, br, x_pcwr, x_stall, x_idex, x_fl}
        tbl[0]  = '{0, 0, 0, 0, 8,  1, 1, 0,  1, 0, 0, 0}; // load $8
        tbl[1]  = '{8, 0, 1, 0, 10, 1, 0, 0,  0, 1, 1, 0}; // reads $8 -> stall
        tbl[2]  = '{8, 0, 1, 0, 10, 1, 0, 0,  1, 0, 0, 0}; // held, EX bubbled
        tbl[3]  = '{0, 0, 0, 0, 0,  1, 1, 0,  1, 0, 0, 0}; // load $0
        tbl[4]  = '{0, 0, 1, 1, 4,  1, 0, 0,  1, 0, 0, 0}; // reads $0 -> none
        tbl[5]  = '{0, 0, 0, 0, 9,  1, 1, 0,  1, 0, 0, 0}; // load $9
        tbl[6]  = '{3, 9, 1, 0, 4,  1, 0, 0,  1, 0, 0, 0}; // Rt=9 unused
        tbl[7]  = '{0, 0, 0, 0, 5,  1, 1, 0,  1, 0, 0, 0}; // load $5
        tbl[8]  = '{5, 5, 1, 1, 6,  1, 0, 1,  1, 0, 1, 1}; // hazard + branch
        tbl[9]  = '{5, 0, 1, 0, 6,  1, 0, 0,  1, 0, 0, 0}; // EX flushed
        tbl[10] = '{0, 0, 0, 0, 7,  1, 1, 0,  1, 0, 0, 0}; // load $7
        tbl[11] = '{1, 7, 1, 1, 2,  1, 0, 0,  0, 1, 1, 0}; // Rs/Rt both hit

        clk = 1'b0;
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Directed table on the LOAD_STALL=1 instance.
        for (int i = 0; i < 12; i++) begin
            set_in(tbl[i].rs, tbl[i].rt, tbl[i].urs, tbl[i].urt,
                   tbl[i].rw, tbl[i].wr, tbl[i].ld, tbl[i].br);
            step(1, tbl[i], $sformatf("vec%0d", i));
        end
        chk("tbl StallCnt0", int'(sc0), 2);
        chk("tbl FlushCnt0", int'(fc0), 1);

        // LOAD_STALL=3: three consecutive stall cycles then RUN.
        do_reset();
        set_in(0, 0, 0, 0, 8, 1, 1, 0);
        step(0, none, "ls3 load");
        set_in(8, 0, 1, 0, 2, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, none, "ls3 use");
            chk($sformatf("ls3 Stall cyc%0d", i), s_stall[1], (i < 3) ? 1 : 0);
            chk($sformatf("ls3 PCWr cyc%0d", i),  s_pcwr[1],  (i < 3) ? 0 : 1);
        end
        chk("ls3 StallCnt1", int'(sc1), 3);
        chk("ls1 StallCnt0", int'(sc0), 1);

        // Reset while the LOAD_STALL=3 instance is mid-stall.
        set_in(0, 0, 0, 0, 8, 1, 1, 0);
        step(0, none, "rmid load");
        set_in(8, 0, 1, 0, 2, 1, 0, 0);
        step(0, none, "rmid use");
        rst = 1'b1;
        step(0, none, "rmid in_reset");
        rst = 1'b0;
        step(0, none, "rmid release");
        chk("rmid PCWr1",     s_pcwr[1],  1);
        chk("rmid Stall1",    s_stall[1], 0);
        chk("rmid StallCnt1", s_sc[1],    0);

        // Saturation: a load reading its own destination stalls every other cycle.
        do_reset();
        set_in(8, 0, 1, 0, 8, 1, 1, 0);
        for (int i = 0; i < 40; i++) step(0, none, "sat");
        chk("sat StallCnt2", int'(sc2), 15);
        chk("sat StallCnt0", int'(sc0), 20);

        // Randomised traffic over a small register set to provoke hazards.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
            rst = ($urandom_range(0, 99) == 0);
            step(0, none, "rand");
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
